// File: rtl/rv_ma_lsu.sv
// rv_ma_lsu: Q103H->Q104H memory-access stage with valid/ready request and valid-only response
//   clk, rst (async, active-low)                  : clock and reset
//   *_Q103H inputs                                : instruction fields held stable by upstream while stalled
//   stall_Q103H                                   : holds Q103H and everything upstream
//   dmem_req_*/dmem_rsp_*                         : D_MEM request (valid/ready) and response (valid only)
//   wb_valid/wb_data/misalign/bus_err _Q104H      : registered write-back and exception flags
//   Optional RV_MA_TIMEOUT_EN: response timeout counter driving bus_err_Q104H
module rv_ma_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_Q103H,
  input  logic              flush_Q103H,
  input  logic              ld_Q103H,
  input  logic              st_Q103H,
  input  logic [1:0]        size_Q103H,
  input  logic              unsigned_Q103H,
  input  logic [1:0]        sel_wb_Q103H,
  input  logic [XLEN-1:0]   pc_plus4_Q103H,
  input  logic [XLEN-1:0]   alu_out_Q103H,
  input  logic [XLEN-1:0]   st_data_Q103H,
  output logic              stall_Q103H,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic              dmem_req_wr_en,
  output logic [XLEN/8-1:0] dmem_req_byte_en,
  output logic [XLEN-1:0]   dmem_req_wr_data,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rd_data,
  output logic              wb_valid_Q104H,
  output logic [XLEN-1:0]   wb_data_Q104H,
  output logic              misalign_Q104H,
  output logic              bus_err_Q104H
);
  localparam int NB = XLEN / 8;
  localparam int NH = NB / 2;
  localparam int NW = NB / 4;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_nxt;
  logic [OW-1:0] off;
  logic mis, mem, req_v, stall, nv, nm;
  logic [XLEN-1:0] nd, rep, shd, keep, ld_fmt, wb_mux;
  logic [NB-1:0] lane;
  logic sb;
  assign off = alu_out_Q103H[OW-1:0];
  assign mem = valid_Q103H && !flush_Q103H && (ld_Q103H || st_Q103H);
  assign mis = (size_Q103H == 2'd1 && off[0]) ||
               (size_Q103H == 2'd2 && off[1:0] != 2'd0) ||
               (size_Q103H == 2'd3 && (off != '0 || XLEN == 32));
  assign lane = (size_Q103H == 2'd0) ? NB'(1) : (size_Q103H == 2'd1) ? NB'(3) :
                (size_Q103H == 2'd2) ? NB'(15) : '1;
  // Replicated data already sits in every lane of its size; aligned accesses make the lane shift an identity.
  assign rep = (size_Q103H == 2'd0) ? {NB{st_data_Q103H[7:0]}} :
               (size_Q103H == 2'd1) ? {NH{st_data_Q103H[15:0]}} :
               (size_Q103H == 2'd2) ? XLEN'({NW{st_data_Q103H[31:0]}}) : st_data_Q103H;
  assign shd  = dmem_rsp_rd_data >> {off, 3'b000};
  assign keep = (size_Q103H == 2'd0) ? XLEN'(32'hFF) : (size_Q103H == 2'd1) ? XLEN'(32'hFFFF) :
                (size_Q103H == 2'd2) ? XLEN'(32'hFFFF_FFFF) : '1;
  assign sb = (size_Q103H == 2'd0) ? shd[7] : (size_Q103H == 2'd1) ? shd[15] :
              (size_Q103H == 2'd2) ? shd[31] : shd[XLEN-1];
  assign ld_fmt = (shd & keep) | (~keep & {XLEN{sb && !unsigned_Q103H}});
  assign wb_mux = (sel_wb_Q103H == 2'd0) ? pc_plus4_Q103H :
                  (sel_wb_Q103H == 2'd1) ? alu_out_Q103H :
                  (sel_wb_Q103H == 2'd2 && ld_Q103H) ? ld_fmt : '0;
  assign dmem_req_addr    = {alu_out_Q103H[XLEN-1:OW], {OW{1'b0}}};
  assign dmem_req_wr_en   = st_Q103H;
  assign dmem_req_byte_en = lane << off;
  assign dmem_req_wr_data = rep;
  // Gated by reset so the channel goes quiet the moment reset asserts.
  assign dmem_req_valid = rst && req_v;
  assign stall_Q103H    = rst && stall;
`ifdef RV_MA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;
  logic to_hit, nb;
  assign to_hit = cnt >= CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus_err_Q104H <= 1'b0;
    else bus_err_Q104H <= nb;
`else
  assign bus_err_Q104H = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    req_v     = 1'b0;
    stall     = 1'b0;
    nv        = 1'b0;
    nm        = 1'b0;
    nd        = wb_data_Q104H;
`ifdef RV_MA_TIMEOUT_EN
    nb        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mem && mis) begin
          nv = 1'b1;
          nm = 1'b1;
          nd = alu_out_Q103H;
        end else if (mem) begin
          req_v = 1'b1;
          if (!dmem_req_ready) stall = 1'b1;
          else if (st_Q103H) begin
            nv = 1'b1;
            nd = wb_mux;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
          end
        end else if (valid_Q103H && !flush_Q103H) begin
          nv = 1'b1;
          nd = wb_mux;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          state_nxt = IDLE;
          nv        = !flush_Q103H;
          nd        = flush_Q103H ? wb_data_Q104H : wb_mux;
        end else if (flush_Q103H) begin
          stall     = 1'b1;
          state_nxt = DRAIN;
        end
`ifdef RV_MA_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = IDLE;
          nv        = 1'b1;
          nb        = 1'b1;
          nd        = alu_out_Q103H;
        end
`endif
        else stall = 1'b1;
      end
      DRAIN: begin
        // Held through the response cycle so a new Q103H instruction is only seen from IDLE.
        stall = 1'b1;
        if (dmem_rsp_valid) state_nxt = IDLE;
`ifdef RV_MA_TIMEOUT_EN
        if (to_hit) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      wb_valid_Q104H <= 1'b0;
      wb_data_Q104H  <= '0;
      misalign_Q104H <= 1'b0;
    end else begin
      state          <= state_nxt;
      wb_valid_Q104H <= nv;
      wb_data_Q104H  <= nd;
      misalign_Q104H <= nm;
    end
endmodule
